// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe: 3-stage SECDED encode, noise-inject and decode channel with valid/ready flow and saturating error counters.
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_valid/o_ready, i_data, i_noise  input beat: data to encode plus codeword error mask
//   o_valid/i_ready, o_data       output beat: corrected data
//   o_1bit_error, o_2bit_error, o_parity_error  per-beat classification, at most one set
//   i_cnt_clr, o_cnt_1bit, o_cnt_2bit  saturating counts of delivered 1-bit / 2-bit beats
module hamming_secded_pipe #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int P  = DATA_W <= 4 ? 3 : DATA_W <= 11 ? 4 : DATA_W <= 26 ? 5 : DATA_W <= 57 ? 6 : 7,
    localparam int CW = DATA_W + P + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CW-1:0]     i_noise,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_1bit_error,
    output logic              o_2bit_error,
    output logic              o_parity_error,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_cnt_1bit,
    output logic [CNT_W-1:0]  o_cnt_2bit
);
    localparam int N = DATA_W + P;
    localparam logic [P-1:0] N_P = P'(N);

    // Hamming position (1-based) of data bit i: the i-th non-power-of-two index.
    function automatic int dpos(input int i);
        int r, c;
        r = 0;
        c = 0;
        for (int k = 1; k <= N; k++)
            if ((k & (k - 1)) != 0) begin
                if (c == i) r = k;
                c++;
            end
        return r;
    endfunction

    logic en, hs;
    logic s1_v_q;
    logic [CW-1:0] s1_code_q, s1_code_d, s1_noise_q;
    logic s2_v_q, s2_par_q, s2_par_d;
    logic [CW-1:0] s2_r_q, s2_r_d;
    logic [P-1:0] s2_syn_q, s2_syn_d, chk;
    logic o_valid_q;
    logic [DATA_W-1:0] data_q, data_d;
    logic f1_q, f1_d, f2_q, f2_d, fp_q, fp_d;
    logic [CW-1:0] fix;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

    assign en  = ~o_valid_q | i_ready;
    assign hs  = o_valid_q & i_ready;

    always_comb begin
        s1_code_d = '0;
        chk = '0;
        for (int i = 0; i < DATA_W; i++) s1_code_d[dpos(i) - 1] = i_data[i];
        // check positions are still zero here, so they drop out of their own groups
        for (int k = 1; k <= N; k++)
            for (int j = 0; j < P; j++)
                if (((k >> j) & 1) != 0) chk[j] = chk[j] ^ s1_code_d[k - 1];
        for (int j = 0; j < P; j++) s1_code_d[(1 << j) - 1] = chk[j];
        s1_code_d[CW-1] = ^s1_code_d[CW-2:0];
    end

    always_comb begin
        s2_r_d = s1_code_q ^ s1_noise_q;
        s2_syn_d = '0;
        for (int k = 1; k <= N; k++)
            if (s2_r_d[k - 1]) s2_syn_d = s2_syn_d ^ P'(k);
        s2_par_d = ^s2_r_d;
    end

    always_comb begin
        f1_d = s2_v_q && s2_par_q && s2_syn_q != '0 && s2_syn_q <= N_P;
        fp_d = s2_v_q && s2_par_q && s2_syn_q == '0;
        // nonzero syndrome that is not a correctable single error: even weight or out of range
        f2_d = s2_v_q && s2_syn_q != '0 && !(s2_par_q && s2_syn_q <= N_P);
        fix = s2_r_q ^ (f1_d ? (CW'(1) << (s2_syn_q - 1'b1)) : '0);
        data_d = '0;
        for (int i = 0; i < DATA_W; i++) data_d[i] = fix[dpos(i) - 1];
    end

    always_comb begin
        cnt1_d = i_cnt_clr ? '0 : (hs && f1_q && cnt1_q != '1) ? cnt1_q + 1'b1 : cnt1_q;
        cnt2_d = i_cnt_clr ? '0 : (hs && f2_q && cnt2_q != '1) ? cnt2_q + 1'b1 : cnt2_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v_q     <= 1'b0;
            s1_code_q  <= '0;
            s1_noise_q <= '0;
            s2_v_q     <= 1'b0;
            s2_r_q     <= '0;
            s2_syn_q   <= '0;
            s2_par_q   <= 1'b0;
            o_valid_q  <= 1'b0;
            data_q     <= '0;
            f1_q       <= 1'b0;
            f2_q       <= 1'b0;
            fp_q       <= 1'b0;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
        end else begin
            if (en) begin
                s1_v_q     <= i_valid;
                s1_code_q  <= s1_code_d;
                s1_noise_q <= i_noise;
                s2_v_q     <= s1_v_q;
                s2_r_q     <= s2_r_d;
                s2_syn_q   <= s2_syn_d;
                s2_par_q   <= s2_par_d;
                o_valid_q  <= s2_v_q;
                data_q     <= data_d;
                f1_q       <= f1_d;
                f2_q       <= f2_d;
                fp_q       <= fp_d;
            end
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign o_ready        = en;
    assign o_valid        = o_valid_q;
    assign o_data         = data_q;
    assign o_1bit_error   = f1_q;
    assign o_2bit_error   = f2_q;
    assign o_parity_error = fp_q;
    assign o_cnt_1bit     = cnt1_q;
    assign o_cnt_2bit     = cnt2_q;
endmodule
